// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Fetch-side branch predictor. It is a direct-mapped BTB with a
//            2-bit saturating counter in each entry.
//            - IF looks up the fetch PC combinationally.
//            - EX trains the table with the resolved outcome and target.
//            - It flags mispredicts and keeps saturating performance counters.
//            - After reset, a sweep clears the whole table before it goes live.
// Ports    : i_clk, i_reset          clock, synchronous active-high reset
//            i_if_pc                 fetch PC to look up
//            o_pred_taken/_target    prediction for i_if_pc
//            o_ready                 table sweep complete, predictor live
//            i_upd_*                 resolved instruction from EX
//            o_mispredict            redirect request (combinational)
//            o_br_count              resolved conditional branches
//            o_mispred_count         mispredicts
// Revision : 1.0  initial release
// ============================================================================
module branch_predictor #(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  output logic        o_ready,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_is_br,
  input  logic        i_upd_is_jmp,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_pred_taken,
  input  logic [31:0] i_upd_pred_target,
  output logic        o_mispredict,
  output logic [31:0] o_br_count,
  output logic [31:0] o_mispred_count
);

  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_sweep_idx;
  logic [IDX_W-1:0]   w_sweep_nxt;

  logic               r_valid  [DEPTH];
  logic [TAG_W-1:0]   r_tag    [DEPTH];
  logic [31:0]        r_target [DEPTH];
  logic [1:0]         r_ctr    [DEPTH];

  logic [31:0]        r_br_count;
  logic [31:0]        r_mispred_count;

  logic               w_run;
  logic [IDX_W-1:0]   w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  logic               w_lk_hit;
  logic [IDX_W-1:0]   w_up_idx;
  logic [TAG_W-1:0]   w_up_tag;
  logic               w_up_hit;
  logic               w_is_jmp;
  logic               w_is_br;
  logic               w_mispredict;
  logic               w_unused;

  // The PC byte offset never takes part in indexing or tag matching.
  assign w_unused = ^{i_if_pc[1:0], i_upd_pc[1:0]};

  assign w_run = (r_state == ST_RUN);

  // ---------------- sweep FSM ----------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_INIT;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_idx;
    case (r_state)
      ST_INIT: begin
        w_sweep_nxt = r_sweep_idx + IDX_W'(1);
        if (r_sweep_idx == IDX_W'(DEPTH - 1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign o_ready = w_run;

  // ---------------- lookup ----------------
  assign w_lk_idx = i_if_pc[IDX_W+1:2];
  assign w_lk_tag = i_if_pc[31:IDX_W+2];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  assign o_pred_taken  = w_run && w_lk_hit && r_ctr[w_lk_idx][1];
  assign o_pred_target = o_pred_taken ? r_target[w_lk_idx] : (i_if_pc + 32'd4);

  // ---------------- update decode ----------------
  assign w_up_idx = i_upd_pc[IDX_W+1:2];
  assign w_up_tag = i_upd_pc[31:IDX_W+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  // If both class bits are set, the instruction is treated as a jump.
  assign w_is_jmp = i_upd_is_jmp;
  assign w_is_br  = i_upd_is_br && !i_upd_is_jmp;

  always_comb begin
    w_mispredict = 1'b0;
    if (w_run && i_upd_valid) begin
      if (w_is_jmp || w_is_br) begin
        w_mispredict = (i_upd_taken != i_upd_pred_taken) ||
                       (i_upd_taken && (i_upd_target != i_upd_pred_target));
      end else begin
        // A non-control instruction that was predicted taken sent fetch astray.
        w_mispredict = i_upd_pred_taken;
      end
    end
  end

  assign o_mispredict = w_mispredict;

  // ---------------- table write ----------------
  // Writes land at the clock edge, so a same-cycle lookup still sees the old entry.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (r_state == ST_INIT) begin
        r_valid[r_sweep_idx] <= 1'b0;
        r_ctr[r_sweep_idx]   <= 2'd0;
      end else if (i_upd_valid) begin
        if (w_is_jmp) begin
          r_valid[w_up_idx]  <= 1'b1;
          r_tag[w_up_idx]    <= w_up_tag;
          r_target[w_up_idx] <= i_upd_target;
          r_ctr[w_up_idx]    <= 2'd3;
        end else if (w_is_br) begin
          if (w_up_hit) begin
            if (i_upd_taken) begin
              r_target[w_up_idx] <= i_upd_target;
              if (r_ctr[w_up_idx] != 2'd3) begin
                r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
              end
            end else if (r_ctr[w_up_idx] != 2'd0) begin
              r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
            end
          end else if (i_upd_taken) begin
            // A new taken branch starts weakly taken.
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= i_upd_target;
            r_ctr[w_up_idx]    <= 2'd2;
          end
        end else if (w_up_hit) begin
          // A non-control instruction matched an entry, so the entry is a stale alias.
          r_valid[w_up_idx] <= 1'b0;
        end
      end
    end
  end

  // ---------------- performance counters ----------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (w_run) begin
      if (i_upd_valid && w_is_br && (r_br_count != 32'hFFFF_FFFF)) begin
        r_br_count <= r_br_count + 32'd1;
      end
      if (w_mispredict && (r_mispred_count != 32'hFFFF_FFFF)) begin
        r_mispred_count <= r_mispred_count + 32'd1;
      end
    end
  end

  assign o_br_count      = r_br_count;
  assign o_mispred_count = r_mispred_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Self-checking bench for branch_predictor. The stimulus process
//            drives directed vectors and queues hand-computed expectations.
//            A monitor process pops the queued expectations each cycle and
//            compares them against the DUT outputs.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ready;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_br;
  logic        upd_is_jmp;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  branch_predictor #(.DEPTH(64)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_if_pc           (if_pc),
    .o_pred_taken      (pred_taken),
    .o_pred_target     (pred_target),
    .o_ready           (ready),
    .i_upd_valid       (upd_valid),
    .i_upd_pc          (upd_pc),
    .i_upd_is_br       (upd_is_br),
    .i_upd_is_jmp      (upd_is_jmp),
    .i_upd_taken       (upd_taken),
    .i_upd_target      (upd_target),
    .i_upd_pred_taken  (upd_pred_taken),
    .i_upd_pred_target (upd_pred_target),
    .o_mispredict      (mispredict),
    .o_br_count        (br_count),
    .o_mispred_count   (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selectors for which DUT output an expectation refers to.
  localparam int S_TAKEN  = 0;
  localparam int S_TARGET = 1;
  localparam int S_READY  = 2;
  localparam int S_MISP   = 3;
  localparam int S_BRCNT  = 4;
  localparam int S_MPCNT  = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // ---------------- monitor ----------------
  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_TAKEN:  return {31'd0, pred_taken};
      S_TARGET: return pred_target;
      S_READY:  return {31'd0, ready};
      S_MISP:   return {31'd0, mispredict};
      S_BRCNT:  return br_count;
      default:  return mispred_count;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = actual(e.sel);
      n_checks++;
      if (a !== e.val) begin
        n_errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, a, e.val, $time);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic expect_val(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                     input logic tk, input logic [31:0] tgt, input logic ptk,
                     input logic [31:0] ptgt);
    upd_valid       = v;
    upd_pc          = pc;
    upd_is_br       = br;
    upd_is_jmp      = jmp;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
  endtask

  task automatic no_upd();
    upd(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt);
    if_pc = pc;
    expect_val({name, "_taken"}, S_TAKEN, {31'd0, tk});
    expect_val({name, "_target"}, S_TARGET, tgt);
  endtask

  task automatic counts(input string name, input logic [31:0] br, input logic [31:0] mp);
    expect_val({name, "_brcnt"}, S_BRCNT, br);
    expect_val({name, "_mpcnt"}, S_MPCNT, mp);
  endtask

  // Sweep of 64 cycles after reset release. Updates are driven in the middle
  // of the sweep so that they land after the sweep has passed their index;
  // later lookups must still miss.
  task automatic sweep(input string name);
    for (int k = 0; k < 64; k++) begin
      expect_val({name, "_ready_low"}, S_READY, 32'd0);
      if (k >= 10 && k <= 20) begin
        if (k % 2 == 0) upd(1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'h600, 1'b0, 32'h108);
        else            upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80,  1'b0, 32'h104);
        expect_val({name, "_init_misp"}, S_MISP, 32'd0);
      end else begin
        no_upd();
      end
      if (k == 0 || k == 63) begin
        look({name, "_init_lk"}, 32'h100, 1'b0, 32'h104);
        counts({name, "_init"}, 32'd0, 32'd0);
      end
      step();
    end
    no_upd();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    if_pc = 32'h100;
    no_upd();
    step();
    reset = 1'b0;
    sweep("s1");

    // R0: live, entries cleared, INIT-time updates left nothing behind
    expect_val("r0_ready", S_READY, 32'd1);
    look("r0", 32'h100, 1'b0, 32'h104);
    counts("r0", 32'd0, 32'd0);
    upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    expect_val("r0_misp", S_MISP, 32'd1);
    step();
    // R1: allocated weakly taken
    look("r1", 32'h100, 1'b1, 32'h80);
    counts("r1", 32'd1, 32'd1);
    upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
    expect_val("r1_misp", S_MISP, 32'd0);
    step();
    // R2: ctr=3, one more taken must saturate
    look("r2", 32'h100, 1'b1, 32'h80);
    counts("r2", 32'd2, 32'd1);
    upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
    step();
    // R3: not taken, predicted taken
    look("r3", 32'h100, 1'b1, 32'h80);
    counts("r3", 32'd3, 32'd1);
    upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h104, 1'b1, 32'h80);
    expect_val("r3_misp", S_MISP, 32'd1);
    step();
    // R4: ctr=2 still predicts taken
    look("r4", 32'h100, 1'b1, 32'h80);
    counts("r4", 32'd4, 32'd2);
    upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h104, 1'b1, 32'h80);
    step();
    // R5: ctr=1 predicts not taken; a correct not-taken update
    look("r5", 32'h100, 1'b0, 32'h104);
    counts("r5", 32'd5, 32'd3);
    upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h104, 1'b0, 32'h104);
    expect_val("r5_misp", S_MISP, 32'd0);
    step();
    // R6: ctr=0, entry stays valid; retrain upward
    look("r6", 32'h100, 1'b0, 32'h104);
    counts("r6", 32'd6, 32'd3);
    upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    step();
    // R7: ctr=1
    look("r7", 32'h100, 1'b0, 32'h104);
    counts("r7", 32'd7, 32'd4);
    upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    step();
    // R8: ctr=2, target mismatch 0x80 vs 0x90
    look("r8", 32'h100, 1'b1, 32'h80);
    counts("r8", 32'd8, 32'd5);
    upd(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h90, 1'b1, 32'h80);
    expect_val("r8_misp", S_MISP, 32'd1);
    step();
    // R9: target overwritten
    look("r9", 32'h100, 1'b1, 32'h90);
    counts("r9", 32'd9, 32'd6);
    no_upd();
    step();
    // R10: alias 0x200 misses; JAL replaces entry 0
    look("r10", 32'h200, 1'b0, 32'h204);
    upd(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h204);
    expect_val("r10_misp", S_MISP, 32'd1);
    step();
    // R11: jump does not count as a branch
    look("r11", 32'h200, 1'b1, 32'h400);
    counts("r11", 32'd9, 32'd7);
    no_upd();
    step();
    // R12: old alias evicted; non-control hit predicted taken
    look("r12", 32'h100, 1'b0, 32'h104);
    upd(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h204, 1'b1, 32'h400);
    expect_val("r12_misp", S_MISP, 32'd1);
    step();
    // R13: entry invalidated; non-control predicted not taken
    look("r13", 32'h200, 1'b0, 32'h204);
    counts("r13", 32'd9, 32'd8);
    upd(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h304, 1'b0, 32'h304);
    expect_val("r13_misp", S_MISP, 32'd0);
    step();
    // R14: fall-through wraps; train index 1 with a jump
    look("r14", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
    upd(1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 32'h108);
    step();
    // R15: index 1 live; reset asserted mid-RUN
    look("r15", 32'h104, 1'b1, 32'h500);
    counts("r15", 32'd9, 32'd9);
    upd(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h304, 1'b0, 32'h304);
    reset = 1'b1;
    step();
    // R16: counters cleared, INIT re-entered
    reset = 1'b0;
    sweep("s2");
    expect_val("r17_ready", S_READY, 32'd1);
    look("r17", 32'h104, 1'b0, 32'h108);
    counts("r17", 32'd0, 32'd0);
    step();
    look("r18", 32'h100, 1'b0, 32'h104);
    step();
    look("r19", 32'h200, 1'b0, 32'h204);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
